// File: rtl/acia_rx.sv
// acia_rx: 8N1 serial receiver for the ACIA.
// Each byte goes into a holding register. Data-available, framing-error and
// overrun flags are cleared by a one-cycle rx_ack strobe.
module acia_rx #(
  parameter int SCW     = 8,
  parameter int sym_cnt = 139
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic [7:0] rx_dat,
  output logic       rx_full,
  output logic       rx_ferr,
  output logic       rx_ovr,
  output logic       rx_busy
);

  localparam logic [SCW-1:0] RELOAD = SCW'(sym_cnt);
  localparam logic [SCW-1:0] HALF   = SCW'(sym_cnt >> 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           s1;
  logic           s2;
  logic           s2_d;
  logic [SCW-1:0] rcnt;
  logic [2:0]     bcnt;
  logic [7:0]     sr;
  logic           fall;
  logic           tick;
  logic           start_ld;
  logic           start_ok;
  logic           shift_en;
  logic           stop_done;

  assign fall = s2_d & ~s2;
  assign tick = (rcnt == '0);

  // Two-flop synchronizer, plus a third flop that remembers the previous s2 for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_d <= 1'b1;
    end else begin
      s1   <= rx_serial;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. Every non-idle state acts only when the bit-rate counter reaches zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = START;
      START:   if (tick) state_nxt = s2 ? IDLE : DATA;
      DATA:    if (tick && bcnt == 3'd7) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes that drive the datapath, plus the busy indication.
  always_comb begin
    rx_busy   = (state != IDLE);
    start_ld  = (state == IDLE) && fall;
    start_ok  = (state == START) && tick && !s2;
    shift_en  = (state == DATA) && tick;
    stop_done = (state == STOP) && tick;
  end

  // Bit-rate counter. A half-period load on the start edge centres every later sample mid-bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt <= '0;
    end else if (start_ld) begin
      rcnt <= HALF;
    end else if (state != IDLE) begin
      if (tick) rcnt <= RELOAD;
      else      rcnt <= rcnt - SCW'(1);
    end
  end

  // Bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt <= 3'd0;
      sr   <= 8'h00;
    end else begin
      if (start_ok)      bcnt <= 3'd0;
      else if (shift_en) bcnt <= bcnt + 3'd1;
      if (shift_en)      sr   <= {s2, sr[7:1]};
    end
  end

  // Holding register and status flags. A completing frame takes priority over a simultaneous ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_dat  <= 8'h00;
      rx_full <= 1'b0;
      rx_ferr <= 1'b0;
      rx_ovr  <= 1'b0;
    end else if (stop_done) begin
      rx_dat  <= sr;
      rx_full <= 1'b1;
      rx_ferr <= ~s2;
      if (rx_ack)       rx_ovr <= 1'b0;
      else if (rx_full) rx_ovr <= 1'b1;
    end else if (rx_ack) begin
      rx_full <= 1'b0;
      rx_ferr <= 1'b0;
      rx_ovr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acia_rx.sv
// tb_acia_rx: randomized scoreboard bench for acia_rx.
// The stimulus pushes expected bytes and flags into a queue. A monitor pops
// and compares each entry when a frame attempt ends.
module tb_acia_rx;

  localparam int BIT_CLKS   = 140;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  localparam int STOP_EDGE  = 1332;

  typedef struct {
    bit         glitch;
    logic [7:0] dat;
    bit         ferr;
    bit         ovr;
    bit         full;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_dat;
  logic       rx_full;
  logic       rx_ferr;
  logic       rx_ovr;
  logic       rx_busy;

  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q[$];

  bit         model_full = 1'b0;
  bit         model_ovr  = 1'b0;
  bit         model_ferr = 1'b0;
  logic [7:0] model_dat  = 8'h00;
  bit         prev_busy  = 1'b0;

  acia_rx #(.SCW(8), .sym_cnt(139)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .rx_ack   (rx_ack),
    .rx_dat   (rx_dat),
    .rx_full  (rx_full),
    .rx_ferr  (rx_ferr),
    .rx_ovr   (rx_ovr),
    .rx_busy  (rx_busy)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllFlags(input string tag);
    checkOutput({tag, "_dat"},  {24'd0, rx_dat},  {24'd0, model_dat});
    checkOutput({tag, "_full"}, {31'd0, rx_full}, {31'd0, model_full});
    checkOutput({tag, "_ferr"}, {31'd0, rx_ferr}, {31'd0, model_ferr});
    checkOutput({tag, "_ovr"},  {31'd0, rx_ovr},  {31'd0, model_ovr});
    checkOutput({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
  endtask

  // Monitor: each time a frame attempt ends, compare against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && prev_busy && rx_busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_frame: got dat %0h with no expectation queued", rx_dat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.glitch) begin
          checkOutput("glitch_full", {31'd0, rx_full}, {31'd0, e.full});
        end else begin
          checkOutput("mon_dat",  {24'd0, rx_dat},  {24'd0, e.dat});
          checkOutput("mon_full", {31'd0, rx_full}, {31'd0, e.full});
          checkOutput("mon_ferr", {31'd0, rx_ferr}, {31'd0, e.ferr});
          checkOutput("mon_ovr",  {31'd0, rx_ovr},  {31'd0, e.ovr});
        end
      end
    end
    prev_busy = (rx_busy === 1'b1);
  end

  task automatic idleCycles(input int n, input logic level);
    for (int i = 0; i < n; i++) begin
      rx_serial = level;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Sends one 8N1 frame. ack_cycle is the edge index (relative to the start bit)
  // at which rx_ack is high, or -1 for none.
  task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input int ack_cycle);
    logic [9:0] fr;
    exp_t       e;
    bit         new_ovr;
    fr = {stop_bit, data, 1'b0};
    if (ack_cycle >= 0 && ack_cycle < STOP_EDGE) begin
      model_full = 1'b0;
      model_ovr  = 1'b0;
      model_ferr = 1'b0;
    end
    new_ovr    = (ack_cycle == STOP_EDGE) ? 1'b0 : (model_ovr | model_full);
    model_full = 1'b1;
    model_ovr  = new_ovr;
    model_ferr = ~stop_bit;
    model_dat  = data;
    e.glitch = 1'b0;
    e.dat    = data;
    e.ferr   = ~stop_bit;
    e.ovr    = new_ovr;
    e.full   = 1'b1;
    exp_q.push_back(e);
    for (int c = 0; c < FRAME_CLKS; c++) begin
      rx_serial = fr[c / BIT_CLKS];
      rx_ack    = (c == ack_cycle);
      @(posedge clk);
      @(negedge clk);
      if (c == 1)             checkOutput("busy_edge1",    {31'd0, rx_busy}, 32'd0);
      if (c == 2)             checkOutput("busy_edge2",    {31'd0, rx_busy}, 32'd1);
      if (c == STOP_EDGE - 1) checkOutput("busy_pre_stop", {31'd0, rx_busy}, 32'd1);
      if (c == STOP_EDGE)     checkOutput("busy_stop",     {31'd0, rx_busy}, 32'd0);
    end
    rx_ack = 1'b0;
    if (ack_cycle > STOP_EDGE) begin
      model_full = 1'b0;
      model_ovr  = 1'b0;
      model_ferr = 1'b0;
    end
  endtask

  task automatic ackPulse();
    rx_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_ack = 1'b0;
    model_full = 1'b0;
    model_ovr  = 1'b0;
    model_ferr = 1'b0;
    checkAllFlags("ack");
  endtask

  task automatic sendGlitch(input int low_clks);
    exp_t e;
    e.glitch = 1'b1;
    e.dat    = 8'h00;
    e.ferr   = 1'b0;
    e.ovr    = 1'b0;
    e.full   = model_full;
    exp_q.push_back(e);
    for (int c = 0; c < 200; c++) begin
      rx_serial = (c < low_clks) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (c == 71) checkOutput("glitch_busy71", {31'd0, rx_busy}, 32'd1);
      if (c == 72) checkOutput("glitch_busy72", {31'd0, rx_busy}, 32'd0);
    end
  endtask

  initial begin
    int acks[4];
    acks[0] = -1;
    acks[1] = 100;
    acks[2] = STOP_EDGE;
    acks[3] = 1350;

    // Power-on reset with an idle line.
    rst = 1'b0;
    idleCycles(5, 1'b1);
    checkAllFlags("por");
    rst = 1'b1;
    idleCycles(10, 1'b1);

    // Set flags, then abort a frame in progress with reset.
    applyStimulus(8'h11, 1'b1, -1);
    idleCycles(300, 1'b0);
    checkOutput("midframe_busy", {31'd0, rx_busy}, 32'd1);
    rst = 1'b0;
    idleCycles(3, 1'b0);
    model_full = 1'b0;
    model_ovr  = 1'b0;
    model_ferr = 1'b0;
    model_dat  = 8'h00;
    checkAllFlags("midreset");
    rst = 1'b1;
    idleCycles(10, 1'b1);
    applyStimulus(8'hA5, 1'b1, -1);

    // Back-to-back frames, each acked before the next stop sample.
    applyStimulus(8'h55, 1'b1, 100);
    applyStimulus(8'h00, 1'b1, 100);
    applyStimulus(8'hFF, 1'b1, 100);
    idleCycles(30, 1'b1);
    ackPulse();

    // Short low glitch on an idle line.
    sendGlitch(20);
    checkOutput("glitch_after_full", {31'd0, rx_full}, 32'd0);

    // Framing error followed by a held-low line.
    applyStimulus(8'h3C, 1'b0, -1);
    idleCycles(2 * FRAME_CLKS, 1'b0);
    checkAllFlags("ferr_hold");
    idleCycles(30, 1'b1);
    applyStimulus(8'h5A, 1'b1, 100);
    idleCycles(20, 1'b1);

    // Overrun, then clear it.
    ackPulse();
    applyStimulus(8'h11, 1'b1, -1);
    applyStimulus(8'h22, 1'b1, -1);
    idleCycles(20, 1'b1);
    checkOutput("ovr_set", {31'd0, rx_ovr}, 32'd1);
    ackPulse();

    // Ack arriving exactly at the stop sample while the overrun flag is set.
    applyStimulus(8'h33, 1'b1, -1);
    applyStimulus(8'h44, 1'b1, -1);
    applyStimulus(8'h66, 1'b1, STOP_EDGE);
    idleCycles(20, 1'b1);
    checkAllFlags("simul");

    // Randomized frames, gaps and ack placement.
    for (int n = 0; n < 8; n++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, acks[$urandom_range(0, 3)]);
      idleCycles(int'($urandom_range(0, 40)), 1'b1);
    end

    idleCycles(200, 1'b1);
    checkAllFlags("final");
    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acia_rx.md
# acia_rx

Serial receive submodule for the ACIA: recovers 8N1 asynchronous frames from the `rx_serial` pin and presents each byte in a holding register for the CPU-side ACIA logic. It is the receive counterpart of the ACIA transmitter and shares its symbol-rate parameters, so both directions run at the same bit rate. Status flags cover data-available, framing error and overrun, all cleared by a one-cycle read acknowledge from the bus interface.

## Interface
- `SCW`, 8: width of the bit-rate counter.
- `sym_cnt`, 139: reload value of the counter. One bit period is `sym_cnt+1` clocks (140 clocks gives 115200 bps at 16 MHz).
- `clk` input, 1 bit: system clock, the only clock.
- `rst` input, 1 bit: reset, synchronous and active-low.
- `rx_serial` input, 1 bit: asynchronous serial line. It idles high.
- `rx_ack` input, 1 bit: one-cycle read strobe that clears `rx_full`, `rx_ferr` and `rx_ovr`.
- `rx_dat` output, 8 bits: last received byte.
- `rx_full` output, 1 bit: holding register contains an unread byte.
- `rx_ferr` output, 1 bit: stop bit of the held byte was sampled as 0.
- `rx_ovr` output, 1 bit: a byte completed while `rx_full` was already set. This flag is sticky.
- `rx_busy` output, 1 bit: a frame is in progress (state is not IDLE).

## Operation
- **Synchronizer:** two flops, `rx_serial` → s1 → s2. Both reset to 1. All decisions use s2. A third flop holds the previous s2 for falling-edge detection.
- **States:** IDLE, START, DATA, STOP.
- **Counter rule, all non-IDLE states:** if `rcnt==0`, perform the state action and reload `sym_cnt[SCW-1:0]`. Otherwise decrement `rcnt`.
- **IDLE:**
  - On a falling edge of s2 (previous s2 = 1, s2 = 0), go to START and load `rcnt` with `sym_cnt>>1` (69 at defaults). This places the samples near mid-bit.
  - A line held low without a preceding high never starts a frame.
- **START action:**
  - If s2=1, it was a false start (glitch): go to IDLE with no flag changes.
  - Otherwise go to DATA and set `bcnt` to 0.
- **DATA action:**
  - Shift s2 into the shift register MSB-first-in, so bits arrive LSB first: `sr <= {s2, sr[7:1]}`.
  - Increment `bcnt`. After the 8th bit (`bcnt==7` at the action), go to STOP.
- **STOP action:**
  - Load `rx_dat <= sr`.
  - Set `rx_ferr <= ~s2` and `rx_full <= 1`.
  - Set `rx_ovr <= 1` if `rx_full==1` and `rx_ack==0` in that cycle. Otherwise leave `rx_ovr` unchanged, except that a simultaneous ack clears it.
  - Go to IDLE.
  - The byte is delivered even on a framing error.
- **Break or held-low line after a framing error:** IDLE waits for s2 to return high and then fall again. No repeated frames are generated.
- **`rx_ack` with no completion in the same cycle:** clears `rx_full`, `rx_ferr` and `rx_ovr`. `rx_dat` is unchanged.
- **Simultaneous STOP completion and `rx_ack`:** completion wins. `rx_full=1`, `rx_ferr` is taken from the new stop bit, `rx_ovr=0`, and `rx_dat` holds the new byte.
- **Overrun:** the newest byte overwrites `rx_dat`. The old byte is lost.
- **Arithmetic:** `rcnt` is SCW bits and never wraps, because it is reloaded at 0. `bcnt` is 3 bits.

## Timing
- **Reset values:** state IDLE, s1/s2/previous-s2 = 1, `rcnt=0`, `bcnt=0`, `sr=0`, `rx_dat=8'h00`, `rx_full=0`, `rx_ferr=0`, `rx_ovr=0`, `rx_busy=0`.
- **Reset mid-frame:** aborts the frame at the next edge. No flag is set, and flags already set are cleared.
- **Reference edge:** let edge 0 be the first clock edge at which s1 samples the start bit low. Then:
  - s2 is low after edge 1.
  - START is entered and `rx_busy` is high after edge 2.
  - The start bit is checked at edge 72.
  - Data bit i (i=0..7) is sampled at edge 72+140·(i+1).
  - The stop bit is sampled at edge 1332, and `rx_full` reads 1 after edge 1332.
  - Values are for default parameters. In general: half-sample at `2 + (sym_cnt>>1) + 1`, then every `sym_cnt+1` clocks.
- **Tolerance:** the receiver accepts a back-to-back next start bit immediately after the stop sample. Tolerance is ±4% of the bit rate.
- **`rx_ack` effect:** takes effect at the edge where it is sampled high. Flags read 0 in the following cycle.

## Test plan
- **Reset:** apply reset low for 3 cycles mid-frame → all outputs reach their reset values, then receive 0xA5 cleanly: `rx_dat=0xA5`, `rx_full=1` after edge 1332, `rx_ferr=0`.
- **Back-to-back frames:** send 0x55, then 0x00, then 0xFF with no idle gap. Ack each byte before the next stop sample → each byte appears in order and `rx_ovr` stays 0.
- **Glitch:** drive a 20-cycle low glitch on an idle line → state returns to IDLE after the start check, with `rx_full=0` and `rx_busy=0` afterwards.
- **Framing error:** send 0x3C with the stop bit driven 0 and the line then held low for 2 frame times → `rx_dat=0x3C`, `rx_full=1`, `rx_ferr=1`. No second byte arrives until the line goes high and falls again.
- **Overrun:** receive 0x11 and do not ack, then receive 0x22 → `rx_dat=0x22`, `rx_ovr=1`. A later `rx_ack` pulse clears `rx_full`, `rx_ferr` and `rx_ovr`.
- **Simultaneous ack:** assert `rx_ack` exactly at the stop-sample edge of a second byte while the first is unread → `rx_full=1`, `rx_ovr=0`, and `rx_dat` holds the second byte.
